// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, geometry helpers and default sizes for the conv stage
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        FLUSH,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    function automatic int out_pix(input int width, input int height, input int k);
        return (width - k + 1) * (height - k + 1);
    endfunction

    // Address width for a memory of 'depth' words, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_WIDTH       = 28;
    localparam int DEF_HEIGHT      = 28;
    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_NUM_FILTER  = 6;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_OUT_PIX     = out_pix(DEF_WIDTH, DEF_HEIGHT, DEF_KERNEL_SIZE);
    localparam int DEF_IMG_AW      = addr_w(DEF_WIDTH * DEF_HEIGHT);
    localparam int DEF_RES_AW      = addr_w(DEF_NUM_FILTER * DEF_OUT_PIX);

endpackage

// File: rtl/conv_pass_sched_if.sv
// rtl/conv_pass_sched_if.sv - control, frame RAM, weight and result RAM signals of the pass scheduler
interface conv_pass_sched_if
    import conv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int NUM_FILTER  = DEF_NUM_FILTER
) ();
    localparam int OUT_PIX = out_pix(WIDTH, HEIGHT, KERNEL_SIZE);
    localparam int FSEL_W  = addr_w(NUM_FILTER);
    localparam int IMG_AW  = addr_w(WIDTH * HEIGHT);
    localparam int RES_AW  = addr_w(NUM_FILTER * OUT_PIX);

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic              wgt_req;
    logic              wgt_ready;
    logic [FSEL_W-1:0] filter_sel;
    logic              buf_rst;
    logic              img_rd_en;
    logic [IMG_AW-1:0] img_addr;
    logic              win_valid;
    logic              res_wr_en;
    logic [RES_AW-1:0] res_addr;

    modport slave (
        input  start, abort, wgt_ready, win_valid,
        output busy, done, err, wgt_req, filter_sel, buf_rst,
               img_rd_en, img_addr, res_wr_en, res_addr
    );

    modport master (
        output start, abort, wgt_ready, win_valid,
        input  busy, done, err, wgt_req, filter_sel, buf_rst,
               img_rd_en, img_addr, res_wr_en, res_addr
    );

endinterface

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - pixel, window and drain counters plus running result-RAM base
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int FRAME   = DEF_WIDTH * DEF_HEIGHT,
    parameter int OUT_PIX = DEF_OUT_PIX,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int IMG_AW  = DEF_IMG_AW,
    parameter int RES_AW  = DEF_RES_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_pix_step,
    input  logic              i_win_step,
    input  logic              i_drain_step,
    input  logic              i_base_clear,
    input  logic              i_base_step,
    output logic [IMG_AW-1:0] o_pix_cnt,
    output logic              o_pix_last,
    output logic              o_win_done,
    output logic              o_drain_last,
    output logic [RES_AW-1:0] o_res_addr
);
    localparam int WIN_W = addr_w(OUT_PIX + 1);
    localparam int DRN_W = addr_w(TIMEOUT);

    logic [IMG_AW-1:0] r_pix_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [DRN_W-1:0]  r_drain_cnt;
    logic [RES_AW-1:0] r_base;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pix_cnt   <= '0;
            r_win_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (i_pix_step)
                r_pix_cnt <= r_pix_cnt + IMG_AW'(1);
            if (i_win_step)
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            if (i_drain_step)
                r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        end
    end

    // Base advances by one filter's worth of outputs per pass instead of multiplying filter_sel.
    always_ff @(posedge clk) begin
        if (rst || i_base_clear)
            r_base <= '0;
        else if (i_base_step)
            r_base <= r_base + RES_AW'(OUT_PIX);
    end

    assign o_pix_cnt    = r_pix_cnt;
    assign o_pix_last   = (r_pix_cnt == IMG_AW'(FRAME - 1));
    assign o_win_done   = (r_win_cnt == WIN_W'(OUT_PIX));
    assign o_drain_last = (r_drain_cnt == DRN_W'(TIMEOUT - 1));
    assign o_res_addr   = r_base + RES_AW'(r_win_cnt);

endmodule

// File: rtl/conv_pass_sched.sv
// rtl/conv_pass_sched.sv - per-filter pass scheduler for the 5x5 convolution stage
module conv_pass_sched
    import conv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int NUM_FILTER  = DEF_NUM_FILTER,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 rst,
    conv_pass_sched_if.slave    io_sched
);
    localparam int OUT_PIX = out_pix(WIDTH, HEIGHT, KERNEL_SIZE);
    localparam int FRAME   = WIDTH * HEIGHT;
    localparam int FSEL_W  = addr_w(NUM_FILTER);
    localparam int IMG_AW  = addr_w(FRAME);
    localparam int RES_AW  = addr_w(NUM_FILTER * OUT_PIX);

    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_wgt_req;
    logic              r_buf_rst;
    logic              r_img_rd_en;
    logic              r_res_wr_en;
    logic [FSEL_W-1:0] r_filter_sel;
    logic [RES_AW-1:0] r_res_addr;
    logic [RES_AW-1:0] w_res_addr;
    logic [IMG_AW-1:0] w_pix_cnt;
    logic              w_pix_last;
    logic              w_win_done;
    logic              w_drain_last;
    logic              w_start_acc;
    logic              w_abort_hit;
    logic              w_win_acc;
    logic              w_last_filter;
    logic              w_advance;

    assign w_start_acc   = (r_state == IDLE) && io_sched.start && !io_sched.abort;
    assign w_abort_hit   = (r_state != IDLE) && io_sched.abort;
    assign w_last_filter = (r_filter_sel == FSEL_W'(NUM_FILTER - 1));
    assign w_advance     = (r_state == NEXT) && (w_next == WLOAD);
    // Windows count only while pixels are flowing and only up to one frame's worth.
    assign w_win_acc     = io_sched.win_valid && !io_sched.abort && !w_win_done &&
                           ((r_state == STREAM) || (r_state == DRAIN));

    conv_addr_gen #(
        .FRAME   (FRAME),
        .OUT_PIX (OUT_PIX),
        .TIMEOUT (TIMEOUT),
        .IMG_AW  (IMG_AW),
        .RES_AW  (RES_AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (r_state == FLUSH),
        .i_pix_step   ((r_state == STREAM) && !w_pix_last && !io_sched.abort),
        .i_win_step   (w_win_acc),
        .i_drain_step (r_state == DRAIN),
        .i_base_clear (w_start_acc),
        .i_base_step  (w_advance),
        .o_pix_cnt    (w_pix_cnt),
        .o_pix_last   (w_pix_last),
        .o_win_done   (w_win_done),
        .o_drain_last (w_drain_last),
        .o_res_addr   (w_res_addr)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_sched.start) w_next = WLOAD;
            WLOAD:   if (io_sched.wgt_ready) w_next = FLUSH;
            FLUSH:   w_next = STREAM;
            STREAM:  if (w_pix_last) w_next = DRAIN;
            DRAIN: begin
                if (w_win_done)
                    w_next = NEXT;
                else if (w_drain_last)
                    w_next = DONE;
            end
            NEXT:    w_next = w_last_filter ? DONE : WLOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (io_sched.abort)
            w_next = IDLE;
    end

    // Strobes are registered from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_wgt_req    <= 1'b0;
            r_buf_rst    <= 1'b1;
            r_img_rd_en  <= 1'b0;
            r_res_wr_en  <= 1'b0;
            r_filter_sel <= '0;
            r_res_addr   <= '0;
        end else begin
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
            r_wgt_req   <= (w_next == WLOAD);
            r_buf_rst   <= (w_next == FLUSH) || w_abort_hit;
            r_img_rd_en <= (w_next == STREAM);
            r_res_wr_en <= w_win_acc;
            if (w_win_acc)
                r_res_addr <= w_res_addr;
            if (w_start_acc)
                r_filter_sel <= '0;
            else if (w_advance)
                r_filter_sel <= r_filter_sel + FSEL_W'(1);
            if (w_start_acc)
                r_err <= 1'b0;
            else if ((r_state == DRAIN) && (w_next == DONE))
                r_err <= 1'b1;
        end
    end

    assign io_sched.busy       = r_busy;
    assign io_sched.done       = r_done;
    assign io_sched.err        = r_err;
    assign io_sched.wgt_req    = r_wgt_req;
    assign io_sched.filter_sel = r_filter_sel;
    assign io_sched.buf_rst    = r_buf_rst;
    assign io_sched.img_rd_en  = r_img_rd_en;
    assign io_sched.img_addr   = w_pix_cnt;
    assign io_sched.res_wr_en  = r_res_wr_en;
    assign io_sched.res_addr   = r_res_addr;

endmodule

// File: tb/tb_conv_pass_sched.sv
// tb/tb_conv_pass_sched.sv - scoreboard bench for conv_pass_sched on an 8x8 frame, two filters
module tb_conv_pass_sched;
    localparam int W     = 8;
    localparam int H     = 8;
    localparam int K     = 5;
    localparam int NF    = 2;
    localparam int TO    = 32;
    localparam int OP    = (W - K + 1) * (H - K + 1);
    localparam int FRAME = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tb_start = 1'b0;
    logic tb_abort = 1'b0;
    logic tb_ready = 1'b1;
    logic tb_stray = 1'b0;
    logic m_win    = 1'b0;
    logic m_stage  = 1'b0;

    conv_pass_sched_if #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K), .NUM_FILTER(NF)) bus ();

    assign bus.start     = tb_start;
    assign bus.abort     = tb_abort;
    assign bus.wgt_ready = tb_ready;
    assign bus.win_valid = m_win | tb_stray;

    conv_pass_sched #(
        .WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K), .NUM_FILTER(NF), .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_sched (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int cyc = 0;
    int m_exp_pix = 0;
    int m_streams = 0;
    int m_rd_total = 0;
    int m_pass = -1;
    int m_win_k = 0;
    int m_win_limit = OP;
    int m_done_cnt = 0;
    int m_done_cyc = 0;
    int m_last_rd_cyc = 0;
    int m_last_wr_cyc = 0;
    bit m_fresh = 1'b0;
    int sb_q[$];

    // Window source model plus output monitor: a window fires one cycle after its bottom-right pixel is read.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            m_win   = m_stage;
            m_stage = 1'b0;
            if (bus.buf_rst) begin
                m_exp_pix = 0;
                m_fresh   = 1'b1;
            end
            if (bus.img_rd_en) begin
                int pa;
                pa = int'(bus.img_addr);
                if (m_fresh) begin
                    m_streams++;
                    m_pass++;
                    m_win_k = 0;
                    m_fresh = 1'b0;
                end
                check("img_addr", 32'(bus.img_addr), m_exp_pix);
                m_exp_pix++;
                m_rd_total++;
                m_last_rd_cyc = cyc;
                if ((pa / W) >= K - 1 && (pa % W) >= K - 1 && m_win_k < m_win_limit) begin
                    m_stage = 1'b1;
                    sb_q.push_back(m_pass * OP + m_win_k);
                    m_win_k++;
                end
            end
            if (bus.res_wr_en) begin
                m_last_wr_cyc = cyc;
                check("res_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0)
                    check("res_addr", 32'(bus.res_addr), sb_q.pop_front());
            end
            if (bus.done) begin
                m_done_cnt++;
                m_done_cyc = cyc;
            end
        end
    end

    task automatic do_start();
        m_pass   = -1;
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 1);
    endtask

    task automatic full_layer(input string tag, input bit stall);
        int s0, r0, d0, hold;
        s0 = m_streams; r0 = m_rd_total; d0 = m_done_cnt;
        sb_q.delete();
        m_win_limit = OP;
        tb_ready    = !stall;
        do_start();
        check({tag, "_busy"}, 32'(bus.busy), 1);
        check({tag, "_wgt_req"}, 32'(bus.wgt_req), 1);
        check({tag, "_fsel0"}, 32'(bus.filter_sel), 0);
        check({tag, "_err_clr"}, 32'(bus.err), 0);
        if (stall) begin
            hold = 0;
            while (bus.wgt_req === 1'b1 && hold < 50) begin
                hold++;
                tb_start = (hold == 3);
                tb_stray = (hold == 3);
                if (hold == 5)
                    check({tag, "_fsel_hold"}, 32'(bus.filter_sel), 0);
                if (hold == 11)
                    tb_ready = 1'b1;
                @(negedge clk);
            end
            tb_start = 1'b0;
            tb_stray = 1'b0;
            check({tag, "_wgt_hold"}, hold, 11);
        end else begin
            @(negedge clk);
        end
        check({tag, "_wgt_drop"}, 32'(bus.wgt_req), 0);
        check({tag, "_flush"}, 32'(bus.buf_rst), 1);
        check({tag, "_no_rd_flush"}, 32'(bus.img_rd_en), 0);
        @(negedge clk);
        check({tag, "_first_rd"}, 32'(bus.img_rd_en), 1);
        check({tag, "_first_addr"}, 32'(bus.img_addr), 0);
        wait_done(tag, 400);
        check({tag, "_err"}, 32'(bus.err), 0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(bus.busy), 0);
        check({tag, "_done_len"}, 32'(bus.done), 0);
        check({tag, "_streams"}, m_streams - s0, NF);
        check({tag, "_rd_cycles"}, m_rd_total - r0, NF * FRAME);
        check({tag, "_done_cnt"}, m_done_cnt - d0, 1);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_done_lat"}, m_done_cyc - m_last_wr_cyc, 2);
    endtask

    task automatic timeout_test();
        int s0, d0;
        s0 = m_streams; d0 = m_done_cnt;
        sb_q.delete();
        m_win_limit = OP - 1;
        tb_ready    = 1'b1;
        do_start();
        wait_done("T", 300);
        check("T_err", 32'(bus.err), 1);
        @(negedge clk);
        check("T_drain_len", m_done_cyc - m_last_rd_cyc, TO + 1);
        check("T_streams", m_streams - s0, 1);
        check("T_done_cnt", m_done_cnt - d0, 1);
        check("T_sb_empty", sb_q.size(), 0);
        check("T_busy_after", 32'(bus.busy), 0);
        check("T_err_sticky", 32'(bus.err), 1);
        m_win_limit = OP;
    endtask

    task automatic abort_test();
        int n, d0;
        d0 = m_done_cnt;
        sb_q.delete();
        tb_ready = 1'b1;
        do_start();
        n = 0;
        while (!(bus.img_rd_en === 1'b1 && bus.img_addr == 30) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("A_reach_30", 32'(bus.img_addr), 30);
        tb_abort = 1'b1;
        @(negedge clk);
        tb_abort = 1'b0;
        check("A_busy", 32'(bus.busy), 0);
        check("A_buf_rst", 32'(bus.buf_rst), 1);
        check("A_rd_en", 32'(bus.img_rd_en), 0);
        check("A_wgt_req", 32'(bus.wgt_req), 0);
        check("A_done", 32'(bus.done), 0);
        check("A_res_wr", 32'(bus.res_wr_en), 0);
        repeat (5) @(negedge clk);
        check("A_no_done", m_done_cnt - d0, 0);
        check("A_idle", 32'(bus.busy), 0);
        check("A_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("R_busy", 32'(bus.busy), 0);
        check("R_done", 32'(bus.done), 0);
        check("R_err", 32'(bus.err), 0);
        check("R_wgt_req", 32'(bus.wgt_req), 0);
        check("R_rd_en", 32'(bus.img_rd_en), 0);
        check("R_res_wr", 32'(bus.res_wr_en), 0);
        check("R_buf_rst", 32'(bus.buf_rst), 1);
        check("R_fsel", 32'(bus.filter_sel), 0);
        check("R_img_addr", 32'(bus.img_addr), 0);
        check("R_res_addr", 32'(bus.res_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        tb_start = 1'b1;
        tb_abort = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        tb_abort = 1'b0;
        check("I_abort_wins_busy", 32'(bus.busy), 0);
        check("I_abort_wins_wgt", 32'(bus.wgt_req), 0);
        full_layer("L1", 1'b0);
        full_layer("S", 1'b1);
        timeout_test();
        full_layer("L2", 1'b0);
        abort_test();
        full_layer("L3", 1'b0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_pass_sched.md
# conv_pass_sched

Pass scheduler for the 5×5 convolution stage. For each of NUM_FILTER filters it runs one pass:
- requests that filter's weights;
- flushes the line buffer;
- streams the stored input frame from frame RAM into the line buffer, one pixel per cycle;
- counts the window-valid strobes coming back and generates result-RAM write addresses.

It sits between the top-level layer controller (start/done) and the frame RAM, weight loader, line buffer and result RAM.

## Interface
Parameters:
- WIDTH, 28, input frame width in pixels
- HEIGHT, 28, input frame height in pixels
- KERNEL_SIZE, 5, kernel side
- NUM_FILTER, 6, filters (passes) per layer
- TIMEOUT, 1024, maximum drain cycles before error

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin layer; sampled in IDLE only
- abort  in  1  cancel current layer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of layer
- err  out  1  sticky drain timeout; cleared by next accepted start or rst
- wgt_req  out  1  weight load request
- wgt_ready  in  1  weight loader acknowledge
- filter_sel  out  max(1,clog2(NUM_FILTER))  current filter index
- buf_rst  out  1  line-buffer synchronous reset
- img_rd_en  out  1  frame RAM read enable
- img_addr  out  clog2(WIDTH*HEIGHT)  frame RAM read address
- win_valid  in  1  one cycle per completed output window
- res_wr_en  out  1  result RAM write enable
- res_addr  out  clog2(NUM_FILTER*OUT_PIX)  result RAM address

## Operation
- Derived constants:
  - OUT_PIX = (WIDTH-KERNEL_SIZE+1)*(HEIGHT-KERNEL_SIZE+1), 576 at defaults.
  - FRAME = WIDTH*HEIGHT.
- States and transitions:
  - IDLE: start → WLOAD. On entry from start: filter_sel=0, err cleared.
  - WLOAD: wgt_req=1 until wgt_ready is sampled high, then → FLUSH.
  - FLUSH: buf_rst=1 for exactly one cycle; pix_cnt=0, win_cnt=0; → STREAM.
  - STREAM: img_rd_en=1, img_addr=pix_cnt, pix_cnt++ each cycle. Issuing addr FRAME-1 → DRAIN.
  - DRAIN: img_rd_en=0, drain_cnt++ each cycle. win_cnt==OUT_PIX → NEXT. drain_cnt==TIMEOUT-1 → err=1, → DONE.
  - NEXT: filter_sel==NUM_FILTER-1 → DONE; otherwise filter_sel++, → WLOAD.
  - DONE: done=1 for one cycle, → IDLE.
- Window counting:
  - In STREAM and DRAIN each win_valid: res_wr_en=1, res_addr=filter_sel*OUT_PIX+win_cnt, win_cnt++.
  - win_valid in any other state is ignored, with no write.
  - win_valid after win_cnt==OUT_PIX is ignored.
- Abort: in any non-IDLE state → IDLE next cycle. On that cycle buf_rst=1 and every other strobe is 0; done is not pulsed. Abort has priority over every other transition.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset values:
  - busy, done, err, wgt_req, img_rd_en, res_wr_en = 0.
  - buf_rst = 1 during reset.
  - filter_sel, img_addr, res_addr = 0.
  - state = IDLE.

## Timing
- All outputs are registered.
- Start cycle t: busy=1 and wgt_req=1 at t+1.
- wgt_ready sampled high at cycle u: wgt_req=0 and buf_rst=1 at u+1. First img_rd_en at u+2 with img_addr=0.
- wgt_ready already high at WLOAD entry: wgt_req is high for exactly one cycle.
- STREAM lasts exactly FRAME cycles, with consecutive addresses and no gaps.
- res_wr_en/res_addr appear one cycle after the win_valid that caused them.
- Last window write (win_cnt reaching OUT_PIX) at cycle w: NEXT at w+1. Next pass's wgt_req at w+2, or done at w+2 for the last filter.
- After DONE: busy=0 on the cycle following the done pulse.

## Structure
- Shared package conv_pkg:
  - state enum (IDLE, WLOAD, FLUSH, STREAM, DRAIN, NEXT, DONE);
  - out_pix(width,height,k) function;
  - address-width constants.
  - The line buffer and result-RAM wrapper use the same constants.
- Natural sub-module: conv_addr_gen.
  - Holds pix_cnt, win_cnt and drain_cnt.
  - res_addr uses a running base register, not a multiplier: base += OUT_PIX on each NEXT.
  - Controls: clear, step, terminal-count flags.

## Test plan
- Reset: hold rst 3 cycles → all outputs at reset values, buf_rst=1, state IDLE.
- Full layer, WIDTH=HEIGHT=8, K=5, NUM_FILTER=2, wgt_ready tied high, model emits win_valid 16× per pass → two 64-address streams; res_addr 0..15 then 16..31; single done pulse; err=0.
- Weight stall: wgt_ready low for 10 cycles → wgt_req held 11 cycles, no img_rd_en until FLUSH has passed.
- Timeout: only 15 win_valid pulses, TIMEOUT=32 → err=1, done pulse 32 cycles into DRAIN, no NEXT.
- Abort mid-STREAM at img_addr=30 → IDLE next cycle, buf_rst=1, no done. A following start restarts at filter 0, addr 0.
- start during busy, plus stray win_valid in WLOAD → both ignored; no res_wr_en, no counter change.
